ram_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one `ram` instance between two requesters, for example instruction fetch (port A) and load/store (port B). Each requester port and the memory port use the same four-phase `txs`/`txe` handshake. The arbiter grants one requester at a time and replays that requester's command to memory. It returns the word and error flag to the granted requester, and it bounds each memory phase with a timeout so a stuck memory cannot hang the core.

---
 rtl/ram_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module      : ram_arbiter
// Description : Two-port round-robin arbiter sharing one txs/txe memory port,
//               with a per-phase memory timeout.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ram_arbiter #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 64,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_txs,
    input  logic                 a_read,
    input  logic                 a_write,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic [WORD_SIZE-1:0] a_value,
    output logic                 a_txe,
    output logic [WORD_SIZE-1:0] a_out,
    output logic                 a_err,
    input  logic                 b_txs,
    input  logic                 b_read,
    input  logic                 b_write,
    input  logic [ADDR_SIZE-1:0] b_addr,
    input  logic [WORD_SIZE-1:0] b_value,
    output logic                 b_txe,
    output logic [WORD_SIZE-1:0] b_out,
    output logic                 b_err,
    output logic                 mem_txs,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_value,
    input  logic                 mem_txe,
    input  logic [WORD_SIZE-1:0] mem_out,
    input  logic                 mem_err,
    output logic                 grant
);

    localparam int CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_DRAIN   = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 prio_q, prio_d;
    logic                 grant_q, grant_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 mem_txs_q, mem_txs_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_value_q, mem_value_d;
    logic [WORD_SIZE-1:0] res_out_q, res_out_d;
    logic                 res_err_q, res_err_d;
    logic                 a_txe_q, a_txe_d, b_txe_q, b_txe_d;
    logic [WORD_SIZE-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
    logic                 a_err_q, a_err_d, b_err_q, b_err_d;

    logic w_timeout;
    logic w_sel_b;
    logic w_own_txs;
    logic w_drain_err;

    assign w_timeout   = (TIMEOUT != 0) && (cnt_q == TO_LAST);
    // B wins only when A is idle or B holds the priority token.
    assign w_sel_b     = b_txs && (!a_txs || prio_q);
    assign w_own_txs   = grant_q ? b_txs : a_txs;
    // Still seeing mem_txe high in DRAIN means we only left on a timeout.
    assign w_drain_err = res_err_q | mem_txe;

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        mem_txs_d   = mem_txs_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_value_d = mem_value_q;
        res_out_d   = res_out_q;
        res_err_d   = res_err_q;
        a_txe_d     = a_txe_q;
        a_out_d     = a_out_q;
        a_err_d     = a_err_q;
        b_txe_d     = b_txe_q;
        b_out_d     = b_out_q;
        b_err_d     = b_err_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (a_txs || b_txs) begin
                    grant_d     = w_sel_b;
                    mem_read_d  = w_sel_b ? b_read  : a_read;
                    mem_write_d = w_sel_b ? b_write : a_write;
                    mem_addr_d  = w_sel_b ? b_addr  : a_addr;
                    mem_value_d = w_sel_b ? b_value : a_value;
                    mem_txs_d   = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_txe) begin
                    res_out_d = mem_out;
                    res_err_d = mem_err;
                    mem_txs_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_DRAIN;
                end else if (w_timeout) begin
                    res_out_d = '0;
                    res_err_d = 1'b1;
                    mem_txs_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!mem_txe || w_timeout) begin
                    if (grant_q) begin
                        b_txe_d = 1'b1;
                        b_out_d = res_out_q;
                        b_err_d = w_drain_err;
                    end else begin
                        a_txe_d = 1'b1;
                        a_out_d = res_out_q;
                        a_err_d = w_drain_err;
                    end
                    cnt_d   = '0;
                    state_d = S_RESPOND;
                end
            end
            S_RESPOND: begin
                cnt_d = '0;
                if (!w_own_txs) begin
                    if (grant_q) begin
                        b_txe_d = 1'b0;
                    end else begin
                        a_txe_d = 1'b0;
                    end
                    prio_d  = ~grant_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            prio_q      <= 1'b0;
            grant_q     <= 1'b0;
            cnt_q       <= '0;
            mem_txs_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_value_q <= '0;
            res_out_q   <= '0;
            res_err_q   <= 1'b0;
            a_txe_q     <= 1'b0;
            a_out_q     <= '0;
            a_err_q     <= 1'b0;
            b_txe_q     <= 1'b0;
            b_out_q     <= '0;
            b_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            mem_txs_q   <= mem_txs_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_value_q <= mem_value_d;
            res_out_q   <= res_out_d;
            res_err_q   <= res_err_d;
            a_txe_q     <= a_txe_d;
            a_out_q     <= a_out_d;
            a_err_q     <= a_err_d;
            b_txe_q     <= b_txe_d;
            b_out_q     <= b_out_d;
            b_err_q     <= b_err_d;
        end
    end

    assign a_txe     = a_txe_q;
    assign a_out     = a_out_q;
    assign a_err     = a_err_q;
    assign b_txe     = b_txe_q;
    assign b_out     = b_out_q;
    assign b_err     = b_err_q;
    assign mem_txs   = mem_txs_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_value = mem_value_q;
    assign grant     = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Directed self-checking bench for ram_arbiter with a 64-word
//               behavioural memory that answers one cycle after each txs edge.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        a_txs, a_read, a_write;
    logic [63:0] a_addr;
    logic [31:0] a_value;
    logic        a_txe, a_err;
    logic [31:0] a_out;
    logic        b_txs, b_read, b_write;
    logic [63:0] b_addr;
    logic [31:0] b_value;
    logic        b_txe, b_err;
    logic [31:0] b_out;
    logic        mem_txs, mem_read, mem_write;
    logic [63:0] mem_addr;
    logic [31:0] mem_value;
    logic        mem_txe, mem_err;
    logic [31:0] mem_out;
    logic        grant;
    logic        stuck;

    logic [31:0] mem_arr [0:63];

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.WORD_SIZE(32), .ADDR_SIZE(64), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .a_txs(a_txs), .a_read(a_read), .a_write(a_write), .a_addr(a_addr), .a_value(a_value),
        .a_txe(a_txe), .a_out(a_out), .a_err(a_err),
        .b_txs(b_txs), .b_read(b_read), .b_write(b_write), .b_addr(b_addr), .b_value(b_value),
        .b_txe(b_txe), .b_out(b_out), .b_err(b_err),
        .mem_txs(mem_txs), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_value(mem_value), .mem_txe(mem_txe), .mem_out(mem_out), .mem_err(mem_err),
        .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: SIZE=64 words, addresses beyond that report an error.
    always @(posedge clk) begin
        if (rst) begin
            mem_txe <= 1'b0;
            mem_out <= 32'd0;
            mem_err <= 1'b0;
        end else if (!stuck) begin
            if (mem_txs && !mem_txe) begin
                mem_txe <= 1'b1;
                if (mem_addr >= 64'd64) begin
                    mem_err <= 1'b1;
                    mem_out <= 32'd0;
                end else begin
                    mem_err <= 1'b0;
                    if (mem_write) mem_arr[mem_addr[5:0]] <= mem_value;
                    if (mem_read)  mem_out <= mem_arr[mem_addr[5:0]];
                end
            end else if (!mem_txs && mem_txe) begin
                mem_txe <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return a_txe;
            1:       return b_txe;
            default: return mem_txs;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic lvl, input string tag);
        logic v;
        int   i;
        v = pick(sel);
        i = 0;
        while (v !== lvl && i < 40) begin
            @(negedge clk);
            i++;
            v = pick(sel);
        end
        chk(tag, {63'd0, v}, {63'd0, lvl});
    endtask

    task automatic txn(input bit port, input bit rd, input bit wr, input logic [63:0] addr,
                       input logic [31:0] val, input string tag);
        if (!port) begin
            a_read = rd; a_write = wr; a_addr = addr; a_value = val; a_txs = 1'b1;
        end else begin
            b_read = rd; b_write = wr; b_addr = addr; b_value = val; b_txs = 1'b1;
        end
        @(negedge clk);
        wait_for(port ? 1 : 0, 1'b1, {tag, "_txe_hi"});
        if (!port) a_txs = 1'b0;
        else       b_txs = 1'b0;
        wait_for(port ? 1 : 0, 1'b0, {tag, "_txe_lo"});
    endtask

    initial begin
        int   n_grant;
        int   a_done;
        int   b_done;
        logic prev;

        rst = 1'b1; stuck = 1'b0;
        a_txs = 0; a_read = 0; a_write = 0; a_addr = '0; a_value = '0;
        b_txs = 0; b_read = 0; b_write = 0; b_addr = '0; b_value = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_grant",   grant,   0);
        chk("rst_a_txe",   a_txe,   0);
        chk("rst_b_txe",   b_txe,   0);
        chk("rst_mem_txs", mem_txs, 0);
        chk("rst_a_out",   a_out,   0);
        chk("rst_mem_addr", mem_addr, 0);

        // Simultaneous writes: A first after reset, then B
        a_write = 1; a_read = 0; a_addr = 64'd0; a_value = 32'd11; a_txs = 1;
        b_write = 1; b_read = 0; b_addr = 64'd1; b_value = 32'd22; b_txs = 1;
        @(negedge clk);
        chk("sw_grant_a",   grant,     0);
        chk("sw_mem_write", mem_write, 1);
        chk("sw_addr_a",    mem_addr,  0);
        chk("sw_value_a",   mem_value, 11);
        wait_for(0, 1'b1, "sw_a_txe_hi");
        chk("sw_b_txe_idle", b_txe, 0);
        a_txs = 0;
        wait_for(0, 1'b0, "sw_a_txe_lo");
        wait_for(2, 1'b1, "sw_b_issue");
        chk("sw_grant_b", grant,     1);
        chk("sw_addr_b",  mem_addr,  1);
        chk("sw_value_b", mem_value, 22);
        wait_for(1, 1'b1, "sw_b_txe_hi");
        b_txs = 0;
        wait_for(1, 1'b0, "sw_b_txe_lo");

        // Fairness: both request continuously, three reads each
        a_write = 0; a_read = 1; a_addr = 64'd0; a_txs = 1;
        b_write = 0; b_read = 1; b_addr = 64'd1; b_txs = 1;
        n_grant = 0; a_done = 0; b_done = 0; prev = 1'b0;
        for (int cyc = 0; cyc < 200 && (a_done + b_done) < 6; cyc++) begin
            @(negedge clk);
            if (mem_txs && !prev) begin
                chk("fair_grant", grant, n_grant % 2);
                n_grant++;
            end
            prev = mem_txs;
            if (a_txs && a_txe) begin
                chk("fair_a_out", a_out, 11);
                a_done++;
                a_txs = 0;
            end else if (!a_txs && !a_txe && a_done < 3) begin
                a_txs = 1;
            end
            if (b_txs && b_txe) begin
                chk("fair_b_out", b_out, 22);
                b_done++;
                b_txs = 0;
            end else if (!b_txs && !b_txe && b_done < 3) begin
                b_txs = 1;
            end
        end
        chk("fair_done",   a_done + b_done, 6);
        chk("fair_grants", n_grant,         6);
        wait_for(1, 1'b0, "fair_b_txe_lo");

        txn(1'b1, 1'b0, 1'b1, 64'd3, 32'd7, "b_wr3");

        // Single read, cycle-exact latency
        a_read = 1; a_write = 0; a_addr = 64'd3; a_txs = 1;
        @(negedge clk);
        chk("rd_mem_txs",  mem_txs,  1);
        chk("rd_mem_addr", mem_addr, 3);
        chk("rd_grant",    grant,    0);
        chk("rd_mem_read", mem_read, 1);
        repeat (3) @(negedge clk);
        chk("rd_txe_early", a_txe, 0);
        @(negedge clk);
        chk("rd_txe",   a_txe, 1);
        chk("rd_a_out", a_out, 7);
        chk("rd_a_err", a_err, 0);
        chk("rd_b_txe", b_txe, 0);
        a_txs = 0;
        @(negedge clk);
        chk("rd_txe_fall", a_txe, 0);

        // Memory error on B, A untouched
        txn(1'b1, 1'b1, 1'b0, 64'd100, 32'd0, "b_err");
        chk("err_b_err",  b_err, 1);
        chk("err_a_out",  a_out, 7);
        chk("err_a_err",  a_err, 0);
        txn(1'b0, 1'b1, 1'b0, 64'd3, 32'd0, "a_after_err");
        chk("after_err_a_err", a_err, 0);
        chk("after_err_a_out", a_out, 7);

        // Timeout with memory stuck
        stuck = 1'b1;
        a_read = 1; a_write = 0; a_addr = 64'd3; a_txs = 1;
        repeat (8) @(negedge clk);
        chk("to_txs_held", mem_txs, 1);
        @(negedge clk);
        chk("to_txs_drop", mem_txs, 0);
        @(negedge clk);
        chk("to_a_txe", a_txe, 1);
        chk("to_a_err", a_err, 1);
        chk("to_a_out", a_out, 0);
        a_txs = 0;
        stuck = 1'b0;
        @(negedge clk);
        chk("to_txe_fall", a_txe, 0);

        // Reset mid-ISSUE
        a_read = 1; a_addr = 64'd3; a_txs = 1;
        @(negedge clk);
        chk("mr_issue", mem_txs, 1);
        rst = 1'b1;
        #1;
        chk("mr_mem_txs",  mem_txs,  0);
        chk("mr_mem_addr", mem_addr, 0);
        chk("mr_mem_read", mem_read, 0);
        chk("mr_a_err",    a_err,    0);
        chk("mr_b_err",    b_err,    0);
        chk("mr_grant",    grant,    0);
        a_txs = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        txn(1'b0, 1'b1, 1'b0, 64'd0, 32'd0, "mr_after");
        chk("mr_after_out", a_out, 11);
        chk("mr_after_err", a_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
